// File: rtl/accumulator_bank_if.sv
// Operation/select/data bundle between a controller and accumulator_bank.
// master: drives Op, selects, EnableBus and BusIn; observes AluA, Carry, Zero.
// slave : the accumulator bank itself.
// IB_BUS is not part of this bundle; it is a tri-state net and stays a plain port.
interface accumulator_bank_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = 2
);
  logic [2:0]       Op;
  logic [SEL_W-1:0] WrSel;
  logic [SEL_W-1:0] RdSel;
  logic [SEL_W-1:0] AluSel;
  logic             EnableBus;
  logic [N-1:0]     BusIn;
  logic [N-1:0]     AluA;
  logic             Carry;
  logic             Zero;

  modport master (
    output Op, WrSel, RdSel, AluSel, EnableBus, BusIn,
    input  AluA, Carry, Zero
  );

  modport slave (
    input  Op, WrSel, RdSel, AluSel, EnableBus, BusIn,
    output AluA, Carry, Zero
  );
endinterface

// File: rtl/accumulator_bank.sv
// Bank of NREG N-bit accumulators with one write port and per-register
// load/clear/inc/dec (and optionally shift/rotate) ops plus Carry/Zero flags.
// Ports:
//   MainClock - rising-edge clock
//   ResetN    - synchronous active-low reset (regs=0, Carry=0, Zero=1)
//   bus       - accumulator_bank_if.slave: Op, WrSel, RdSel, AluSel,
//               EnableBus, BusIn in; AluA (combinational), Carry, Zero out
//   IB_BUS    - tri-state view of reg[RdSel], driven while EnableBus=1
// Build option: define ACC_SHIFT_EN to build SHL/SHR/ROL (ops 101/110/111);
// without it those ops behave as HOLD.
module accumulator_bank #(
  parameter int unsigned N     = 4,
  parameter int unsigned NREG  = 4,
  parameter int unsigned SEL_W = 2
) (
  input  logic             MainClock,
  input  logic             ResetN,
  accumulator_bank_if.slave bus,
  output wire  [N-1:0]     IB_BUS
);

  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_CLEAR = 3'b010;
  localparam logic [2:0] OP_INC   = 3'b011;
  localparam logic [2:0] OP_DEC   = 3'b100;
`ifdef ACC_SHIFT_EN
  localparam logic [2:0] OP_SHL   = 3'b101;
  localparam logic [2:0] OP_SHR   = 3'b110;
  localparam logic [2:0] OP_ROL   = 3'b111;
`endif

  logic [N-1:0] regs [NREG];
  logic         carry_q;
  logic         zero_q;

  logic [N-1:0] cur;
  logic         wr_hit;
  logic         upd;
  logic [N-1:0] nval;
  logic         ncarry;
  logic [N-1:0] rd_val;
  logic [N-1:0] alu_val;

  // Fetch the write target; an out-of-range WrSel never hits.
  always_comb begin
    cur    = '0;
    wr_hit = 1'b0;
    for (int i = 0; i < int'(NREG); i++) begin
      if (bus.WrSel == SEL_W'(i)) begin
        cur    = regs[i];
        wr_hit = 1'b1;
      end
    end
  end

  // Next value and carry for the target register.
  always_comb begin
    upd    = 1'b0;
    nval   = cur;
    ncarry = carry_q;
    case (bus.Op)
      OP_LOAD: begin
        upd  = 1'b1;
        nval = bus.BusIn;
      end
      OP_CLEAR: begin
        upd    = 1'b1;
        nval   = '0;
        ncarry = 1'b0;
      end
      OP_INC: begin
        upd    = 1'b1;
        nval   = cur + N'(1);
        ncarry = &cur;
      end
      OP_DEC: begin
        upd    = 1'b1;
        nval   = cur - N'(1);
        ncarry = (cur == '0);
      end
`ifdef ACC_SHIFT_EN
      OP_SHL: begin
        upd    = 1'b1;
        nval   = {cur[N-2:0], 1'b0};
        ncarry = cur[N-1];
      end
      OP_SHR: begin
        upd    = 1'b1;
        nval   = {1'b0, cur[N-1:1]};
        ncarry = cur[0];
      end
      OP_ROL: begin
        upd    = 1'b1;
        nval   = {cur[N-2:0], cur[N-1]};
        ncarry = cur[N-1];
      end
`endif
      default: ;
    endcase
    if (!wr_hit) begin
      upd = 1'b0;
    end
  end

  // Register array and flags; only the selected register is written.
  always_ff @(posedge MainClock) begin
    if (!ResetN) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs[i] <= '0;
      end
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
    end else if (upd) begin
      for (int i = 0; i < int'(NREG); i++) begin
        if (bus.WrSel == SEL_W'(i)) begin
          regs[i] <= nval;
        end
      end
      carry_q <= ncarry;
      zero_q  <= (nval == '0);
    end
  end

  // Read muxes: pre-edge values, out-of-range select reads as zero.
  always_comb begin
    rd_val  = '0;
    alu_val = '0;
    for (int i = 0; i < int'(NREG); i++) begin
      if (bus.RdSel == SEL_W'(i)) begin
        rd_val = regs[i];
      end
      if (bus.AluSel == SEL_W'(i)) begin
        alu_val = regs[i];
      end
    end
  end

  assign bus.AluA  = alu_val;
  assign bus.Carry = carry_q;
  assign bus.Zero  = zero_q;
  assign IB_BUS    = bus.EnableBus ? rd_val : {N{1'bz}};

endmodule
